// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction format, opcodes reused by the control unit,
// the pipeline bubble encoding and the fetch FSM states.
package cpu_pkg;

  localparam int unsigned INSTR_WIDTH  = 9;
  localparam int unsigned OPCODE_WIDTH = 5;
  localparam int unsigned ARG_WIDTH    = INSTR_WIDTH - OPCODE_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_JUMP = 5'b11000;
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 5'b11010;
  localparam logic [OPCODE_WIDTH-1:0] OP_RSVD = 5'b11011;

  // Reserved opcode decodes as a no-op, so it is safe to push down the pipe.
  localparam logic [INSTR_WIDTH-1:0] BUBBLE_INSTR = {OP_RSVD, 4'b0000};

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalted
  } fetch_state_e;

  function automatic logic [OPCODE_WIDTH-1:0] opcode_of(logic [INSTR_WIDTH-1:0] instr);
    return instr[INSTR_WIDTH-1:ARG_WIDTH];
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port: fetch drives address/enable, memory returns data
// one cycle after an enabled read.
interface instruction_fetch_if #(
  parameter int unsigned PC_WIDTH    = 10,
  parameter int unsigned INSTR_WIDTH = 9
);

  logic                   imem_rd_en;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_data;

  modport master (
    output imem_rd_en,
    output imem_addr,
    input  imem_data
  );

  modport slave (
    input  imem_rd_en,
    input  imem_addr,
    output imem_data
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush inserts a bubble, hold freezes contents, otherwise
// it captures the fetched word when one is available and a bubble when not.
module if_id_reg #(
  parameter int unsigned PC_WIDTH    = 10,
  parameter int unsigned INSTR_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   hold,
  input  logic                   load,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [PC_WIDTH-1:0]    pc_in,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   valid,
  output logic [PC_WIDTH-1:0]    pc
);
  import cpu_pkg::*;

  localparam logic [INSTR_WIDTH-1:0] Bubble = INSTR_WIDTH'(BUBBLE_INSTR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr <= Bubble;
      valid <= 1'b0;
      pc    <= '0;
    end else if (flush) begin
      instr <= Bubble;
      valid <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        instr <= instr_in;
        pc    <= pc_in;
        valid <= 1'b1;
      end else begin
        instr <= Bubble;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Front pipeline stage: PC and start/halt FSM, synchronous instruction-memory reads,
// redirect with single-bubble flush, stall by re-reading the in-flight address.
module instruction_fetch #(
  parameter int unsigned          PC_WIDTH    = 10,
  parameter int unsigned          INSTR_WIDTH = 9,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  parameter int unsigned          COUNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [PC_WIDTH-1:0]     branch_target,
  input  logic                    halt,
  instruction_fetch_if.master     imem,
  output logic [INSTR_WIDTH-1:0]  instr_out,
  output logic                    instr_valid,
  output logic [PC_WIDTH-1:0]     pc_out,
  output logic                    halted,
  output logic [COUNT_WIDTH-1:0]  instr_count
);
  import cpu_pkg::*;

  fetch_state_e           state_q;
  logic [PC_WIDTH-1:0]    fetch_pc_q;
  logic [PC_WIDTH-1:0]    pend_pc_q;
  logic                   pend_q;
  logic                   halted_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic running, do_halt, do_redirect, do_stall, do_advance;

  // Priority inside RUN: halt > redirect > stall > normal advance.
  assign running     = (state_q == StRun);
  assign do_halt     = running && halt;
  assign do_redirect = running && !halt && branch_taken;
  assign do_stall    = running && !halt && !branch_taken && stall;
  assign do_advance  = running && !halt && !branch_taken && !stall;

  always_comb begin
    imem.imem_rd_en = running && !halt;
    imem.imem_addr  = fetch_pc_q;
    if (do_redirect) begin
      imem.imem_addr = branch_target;
    end else if (do_stall) begin
      imem.imem_addr = pend_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      pend_q     <= 1'b0;
      halted_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StHalted: begin
          if (start) begin
            state_q    <= StRun;
            fetch_pc_q <= RESET_PC;
            pend_q     <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= '0;
          end
        end
        StRun: begin
          if (halt) begin
            state_q  <= StHalted;
            pend_q   <= 1'b0;
            halted_q <= 1'b1;
          end else if (branch_taken) begin
            fetch_pc_q <= branch_target + 1'b1;
            pend_pc_q  <= branch_target;
            pend_q     <= 1'b1;
          end else if (!stall) begin
            fetch_pc_q <= fetch_pc_q + 1'b1;
            pend_pc_q  <= fetch_pc_q;
            pend_q     <= 1'b1;
            if (pend_q && (count_q != '1)) begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  if_id_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (do_halt || do_redirect),
    .hold     (!do_advance),
    .load     (pend_q),
    .instr_in (imem.imem_data),
    .pc_in    (pend_pc_q),
    .instr    (instr_out),
    .valid    (instr_valid),
    .pc       (pc_out)
  );

  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a delivered-stream model of fetch.
module tb_instruction_fetch;
  import cpu_pkg::*;

  localparam int unsigned PW  = 10;
  localparam int unsigned IW  = 9;
  localparam int unsigned CW  = 16;
  localparam int unsigned CW2 = 3;
  localparam int          NPC = 1 << PW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, stall, branch_taken, halt;
  logic [PW-1:0] branch_target;

  logic [IW-1:0]  instr_out, instr_out2;
  logic           instr_valid, instr_valid2, halted, halted2;
  logic [PW-1:0]  pc_out, pc_out2;
  logic [CW-1:0]  cnt;
  logic [CW2-1:0] cnt2;

  instruction_fetch_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();
  instruction_fetch_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus2 ();

  instruction_fetch #(
    .PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(10'd0), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt), .imem(bus), .instr_out(instr_out),
    .instr_valid(instr_valid), .pc_out(pc_out), .halted(halted), .instr_count(cnt)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  instruction_fetch #(
    .PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(10'd0), .COUNT_WIDTH(CW2)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt), .imem(bus2), .instr_out(instr_out2),
    .instr_valid(instr_valid2), .pc_out(pc_out2), .halted(halted2), .instr_count(cnt2)
  );

  logic [IW-1:0] mem [NPC];
  always @(posedge clk) if (bus.imem_rd_en) bus.imem_data <= mem[bus.imem_addr];
  always @(posedge clk) if (bus2.imem_rd_en) bus2.imem_data <= mem[bus2.imem_addr];

  int checks = 0;
  int failures = 0;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(longint n, int w);
    longint m = (longint'(1) << w) - 1;
    return (n > m) ? m : n;
  endfunction

  // Model: a mode, the next PC to fetch, the addresses read but not yet delivered,
  // and the number of instructions handed to decode since the last start.
  typedef enum int {MIdle, MRun, MHalted} mmode_e;
  mmode_e        m_mode;
  int            m_next;
  int            m_flight[$];
  logic [IW-1:0] m_instr;
  logic          m_valid;
  int            m_pc;
  logic          m_halted;
  longint        m_delivered;
  bit            m_live = 1'b0;

  always @(negedge clk) begin
    logic exp_rd;
    if (m_live) begin
      cmp("valid", instr_valid, m_valid);
      if (m_valid) begin
        cmp("instr", instr_out, m_instr);
        cmp("pc_out", pc_out, m_pc);
      end else begin
        cmp("bubble", instr_out, BUBBLE_INSTR);
      end
      cmp("halted", halted, m_halted);
      cmp("count", cnt, 32'(sat(m_delivered, CW)));
      cmp("sat_valid", instr_valid2, m_valid);
      if (m_valid) cmp("sat_pc_out", pc_out2, m_pc);
      else cmp("sat_bubble", instr_out2, BUBBLE_INSTR);
      cmp("sat_halted", halted2, m_halted);
      cmp("sat_count", cnt2, 32'(sat(m_delivered, CW2)));
      exp_rd = (m_mode == MRun) && !halt;
      cmp("rd_en", bus.imem_rd_en, exp_rd);
      if (exp_rd) begin
        if (branch_taken) cmp("addr_redirect", bus.imem_addr, branch_target);
        else if (stall) begin
          if (m_flight.size() > 0) cmp("addr_reread", bus.imem_addr, m_flight[0]);
        end else cmp("addr", bus.imem_addr, m_next);
      end
    end
    // Advance the model with the inputs the next rising edge will sample.
    if (!rst_n) begin
      m_live = 1'b1; m_mode = MIdle; m_next = 0; m_flight.delete();
      m_instr = BUBBLE_INSTR; m_valid = 1'b0; m_pc = 0; m_halted = 1'b0; m_delivered = 0;
    end else if (m_live) begin
      case (m_mode)
        MIdle, MHalted: if (start) begin
          m_mode = MRun; m_next = 0; m_flight.delete(); m_halted = 1'b0; m_delivered = 0;
        end
        MRun: begin
          if (halt) begin
            m_mode = MHalted; m_flight.delete(); m_halted = 1'b1;
            m_valid = 1'b0; m_instr = BUBBLE_INSTR;
          end else if (branch_taken) begin
            m_flight.delete(); m_flight.push_back(int'(branch_target));
            m_next = (int'(branch_target) + 1) % NPC;
            m_valid = 1'b0; m_instr = BUBBLE_INSTR;
          end else if (!stall) begin
            if (m_flight.size() > 0) begin
              m_pc = m_flight.pop_front();
              m_instr = mem[m_pc]; m_valid = 1'b1; m_delivered++;
            end else begin
              m_valid = 1'b0; m_instr = BUBBLE_INSTR;
            end
            m_flight.push_back(m_next);
            m_next = (m_next + 1) % NPC;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic go(bit r, bit s, bit st, bit b, int t, bit h);
    @(posedge clk);
    #1;
    rst_n = r; start = s; stall = st; branch_taken = b; branch_target = t[PW-1:0]; halt = h;
  endtask

  task automatic idle_run(int n);
    for (int i = 0; i < n; i++) go(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    branch_target = '0;
    for (int i = 0; i < NPC; i++) mem[i] = (i < 6) ? IW'(i) : IW'($urandom);

    go(0, 0, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("rst_valid", instr_valid, 0);
    cmp("rst_instr", instr_out, BUBBLE_INSTR);
    cmp("rst_pc", pc_out, 0);
    cmp("rst_halted", halted, 0);
    cmp("rst_count", cnt, 0);
    cmp("rst_rd_en", bus.imem_rd_en, 0);

    // Start, first deliveries from addresses 0..
    go(1, 1, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("first_rd_en", bus.imem_rd_en, 1);
    cmp("first_addr", bus.imem_addr, 0);
    cmp("first_not_valid", instr_valid, 0);
    go(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("lat_not_valid", instr_valid, 0);
    go(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("d0_valid", instr_valid, 1);
    cmp("d0_pc", pc_out, 0);
    cmp("d0_instr", instr_out, 0);
    cmp("d0_count", cnt, 1);
    go(1, 0, 0, 0, 0, 0);
    go(1, 0, 1, 0, 0, 0);
    @(negedge clk);
    cmp("pre_stall_pc", pc_out, 2);
    cmp("stall_addr", bus.imem_addr, 3);
    go(1, 0, 1, 0, 0, 0);
    go(1, 0, 1, 0, 0, 0);
    go(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("stall_pc", pc_out, 2);
    cmp("stall_instr", instr_out, 2);
    cmp("stall_count", cnt, 3);
    go(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("post_stall_pc", pc_out, 3);
    cmp("post_stall_count", cnt, 4);
    go(1, 0, 0, 0, 0, 0);
    go(1, 0, 0, 1, 'h040, 0);
    @(negedge clk);
    cmp("pre_br_pc", pc_out, 5);
    go(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("br_bubble_valid", instr_valid, 0);
    cmp("br_bubble_instr", instr_out, BUBBLE_INSTR);
    go(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("br_pc0", pc_out, 'h040);
    go(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("br_pc1", pc_out, 'h041);

    // Redirect beats stall; halt beats both.
    go(1, 0, 1, 1, 'h100, 0);
    go(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("brst_bubble", instr_valid, 0);
    go(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("brst_pc", pc_out, 'h100);
    go(1, 0, 1, 1, 'h200, 1);
    go(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("halt_halted", halted, 1);
    cmp("halt_rd_en", bus.imem_rd_en, 0);
    cmp("halt_valid", instr_valid, 0);

    // Restart from HALTED.
    go(1, 1, 0, 0, 0, 0);
    idle_run(3);
    @(negedge clk);
    cmp("restart_pc", pc_out, 0);
    cmp("restart_count", cnt, 1);
    cmp("restart_halted", halted, 0);

    // PC wrap at the top of the address space.
    go(1, 0, 0, 1, 'h3FE, 0);
    idle_run(2);
    @(negedge clk);
    cmp("wrap_pc_3fe", pc_out, 'h3FE);
    go(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("wrap_pc_3ff", pc_out, 'h3FF);
    go(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("wrap_pc_000", pc_out, 0);
    idle_run(10);
    @(negedge clk);
    cmp("sat_count_lit", cnt2, 7);

    // Reset in the middle of RUN.
    go(0, 0, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("mrst_valid", instr_valid, 0);
    cmp("mrst_instr", instr_out, BUBBLE_INSTR);
    cmp("mrst_pc", pc_out, 0);
    cmp("mrst_count", cnt, 0);
    cmp("mrst_rd_en", bus.imem_rd_en, 0);

    go(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, s, st, b, h;
      int t;
      r  = ($urandom_range(0, 199) != 0);
      s  = ($urandom_range(0, 15) == 0);
      st = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 9) == 0);
      h  = ($urandom_range(0, 39) == 0);
      t  = ($urandom_range(0, 3) == 0) ? 1020 + int'($urandom_range(0, 3))
                                       : int'($urandom_range(0, NPC - 1));
      go(r, s, st, b, t, h);
    end
    go(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front pipeline stage: owns the PC, issues synchronous reads to instruction memory, and holds the IF/ID register that drives the 9-bit `instruction_in` bus of the decode/control stage.
- Handles start/halt sequencing, branch/jump redirect with flush, and hazard stalls.
- Keeps a dynamic count of delivered instructions.

Parameters:
- PC_WIDTH, 10, width of PC and instruction-memory address.
- INSTR_WIDTH, 9, instruction width (5-bit opcode + 4-bit operand field).
- RESET_PC, 0, PC loaded on every start.
- COUNT_WIDTH, 16, width of dynamic instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  pulse; begins execution at RESET_PC from IDLE or HALTED.
- stall  in  1  hazard stall from decode; holds IF/ID and PC.
- branch_taken  in  1  redirect request from branch resolution.
- branch_target  in  PC_WIDTH  redirect address.
- halt  in  1  decoded halt (control unit halted flag).
- imem_rd_en  out  1  memory read enable.
- imem_addr  out  PC_WIDTH  memory read address.
- imem_data  in  INSTR_WIDTH  read data, valid one cycle after an enabled read.
- instr_out  out  INSTR_WIDTH  IF/ID instruction to decode.
- instr_valid  out  1  instr_out is a real instruction.
- pc_out  out  PC_WIDTH  PC of instr_out.
- halted  out  1  fetch is in HALTED.
- instr_count  out  COUNT_WIDTH  delivered-instruction count.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; fetch_pc=RESET_PC; pend=0; instr_out=BUBBLE_INSTR; instr_valid=0; pc_out=0; halted=0; instr_count=0; imem_rd_en=0.
- Reset mid-operation discards all in-flight reads.
- States: IDLE, RUN, HALTED.
- IDLE:
  - imem_rd_en=0.
  - start=1 -> RUN, fetch_pc=RESET_PC, instr_count=0.
- RUN, normal cycle (stall=0, no redirect):
  - imem_rd_en=1, imem_addr=fetch_pc; fetch_pc<=fetch_pc+1; pend<=1; pend_pc<=fetch_pc.
  - If pend=1 at the edge: instr_out<=imem_data, pc_out<=pend_pc, instr_valid<=1, instr_count+1.
  - Latency: start edge -> first read next cycle -> instr_valid=1 two edges after start.
- Stall (stall=1, no redirect):
  - fetch_pc, instr_out, pc_out and instr_valid are held.
  - imem_rd_en=1 with imem_addr=pend_pc (re-read) so the in-flight word is re-presented.
  - instr_count is held.
  - Multi-cycle stalls lose no instruction and duplicate none.
- Redirect (branch_taken=1 in RUN):
  - fetch_pc<=branch_target+1; imem_addr=branch_target this cycle; pend_pc<=branch_target.
  - The old in-flight word is discarded: instr_out<=BUBBLE_INSTR, instr_valid<=0, count not incremented.
  - Exactly one bubble per redirect.
  - Redirect overrides stall.
- Halt (halt=1 in RUN):
  - -> HALTED; imem_rd_en=0; pend<=0; instr_out<=BUBBLE_INSTR; instr_valid<=0; halted<=1.
  - Halt overrides both redirect and stall.
- HALTED:
  - Outputs held at bubble; halted=1; instr_count frozen.
  - start=1 -> RUN at RESET_PC, halted<=0, instr_count<=0.
- start while in RUN is ignored.
- PC arithmetic is modulo 2^PC_WIDTH: the address after all-ones wraps to 0 silently.
- instr_count saturates at all-ones.
- pc_out is meaningful only when instr_valid=1.

Decomposition:
- Shared cpu_pkg holds:
  - INSTR_WIDTH and the opcode constants (HALT=5'b11010, JUMP=5'b11000, reserved 5'b11011, etc.), shared with the control unit.
  - BUBBLE_INSTR = {5'b11011, 4'b0000}.
  - Fetch state encoding: IDLE, RUN, HALTED.
- One sub-module: if_id_reg, the IF/ID pipeline register with hold (stall) and flush (bubble insert) controls.
- The FSM and PC logic stay in instruction_fetch.

Test Plan:
- Reset, start pulse, memory holds 0x000..0x005 at addr 0..5 -> instr_valid rises 2 cycles after start; pc_out=0,1,2,3 on successive cycles; instr_count=4 after 4 deliveries.
- Stall held 3 cycles while pc_out=2 -> instr_out/pc_out frozen at 2 and count held; after release pc_out=3 follows with no skip or duplicate.
- branch_taken=1, branch_target=0x040 while pc_out=5 -> exactly one bubble (instr_valid=0, BUBBLE_INSTR), then pc_out=0x040, 0x041.
- branch_taken and stall asserted together -> redirect applied; branch_taken, halt and stall asserted together -> HALTED, halted=1, imem_rd_en=0.
- In HALTED, pulse start -> pc_out restarts at 0, instr_count resets to 0; additionally, rst_n=0 mid-RUN -> all outputs at reset values next cycle.
- fetch_pc at 0x3FF -> next fetched PC is 0x000; preloaded instr_count=0xFFFF stays 0xFFFF after a further delivery.
